// File: rtl/nn_pkg.sv
// Shared constants, state encoding and scaling helper for the classification result scorer.
package nn_pkg;

   localparam int NUM_SAMPLES = 750;
   localparam int CNT_W       = 10;
   localparam int DATA_W      = 8;
   localparam int PCT_W       = 7;
   localparam int NUM_W       = CNT_W + 7;
   localparam int PCT_SCALE   = 100;

   typedef enum logic [1:0] {
      SC_IDLE,
      SC_COLLECT,
      SC_DIVIDE,
      SC_REPORT
   } scorer_state_e;

   // correct*100 always fits in NUM_W bits while the count is bounded by NUM_SAMPLES
   function automatic logic [NUM_W-1:0] scale_pct(input logic [CNT_W-1:0] cnt);
      return NUM_W'(cnt) * NUM_W'(PCT_SCALE);
   endfunction

endpackage

// File: rtl/nn_result_scorer_if.sv
// Result bus between the NN datapath/label ROM side and the scorer.
interface nn_result_scorer_if;
   import nn_pkg::*;

   logic              res_valid;
   logic [DATA_W-1:0] res_pred;
   logic [DATA_W-1:0] res_label;
   logic              last;
   logic [CNT_W-1:0]  sample_idx;

   modport master (
      output res_valid,
      output res_pred,
      output res_label,
      output last,
      input  sample_idx
   );

   modport slave (
      input  res_valid,
      input  res_pred,
      input  res_label,
      input  last,
      output sample_idx
   );

endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; done/quot are valid on the final iteration.
module seq_divider
   import nn_pkg::*;
#(
   parameter int N_W = NUM_W,
   parameter int D_W = CNT_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic [N_W-1:0] num,
   input  logic [D_W-1:0] den,
   output logic           done,
   output logic [N_W-1:0] quot
);

   localparam int IT_W = $clog2(N_W + 1);

   // Dividend bits leave at the MSB while quotient bits enter at the LSB.
   logic [N_W-1:0]  acc_q, acc_d;
   logic [D_W:0]    rem_q, rem_d;
   logic [D_W-1:0]  den_q, den_d;
   logic [IT_W-1:0] iter_q, iter_d;
   logic            busy_q, busy_d;
   logic [D_W+1:0]  rem_sh;
   logic [D_W:0]    diff;
   logic            q_bit;

   always_comb begin
      acc_d  = acc_q;
      rem_d  = rem_q;
      den_d  = den_q;
      iter_d = iter_q;
      busy_d = busy_q;
      done   = 1'b0;

      rem_sh = {rem_q, acc_q[N_W-1]};
      diff   = rem_sh[D_W:0] - {1'b0, den_q};
      q_bit  = (rem_sh >= {2'b00, den_q});

      if (abort) begin
         busy_d = 1'b0;
      end else if (start) begin
         acc_d  = num;
         rem_d  = '0;
         den_d  = den;
         iter_d = IT_W'(N_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         acc_d  = {acc_q[N_W-2:0], q_bit};
         rem_d  = q_bit ? diff : rem_sh[D_W:0];
         iter_d = iter_q - IT_W'(1);
         if (iter_q == IT_W'(1)) begin
            busy_d = 1'b0;
            done   = 1'b1;
         end
      end

      quot = acc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         rem_q  <= '0;
         den_q  <= '0;
         iter_q <= '0;
         busy_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         rem_q  <= rem_d;
         den_q  <= den_d;
         iter_q <= iter_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/nn_result_scorer.sv
// Scores NN classification results against golden labels and reports integer accuracy percent.
module nn_result_scorer
   import nn_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   nn_result_scorer_if.slave    res,
   output logic [CNT_W-1:0]     correct_cnt,
   output logic [CNT_W-1:0]     total_cnt,
   output logic [PCT_W-1:0]     accuracy,
   output logic                 acc_valid,
   output logic                 busy,
   output logic                 overflow
);

   scorer_state_e    state_q, state_d;
   logic [CNT_W-1:0] correct_q, correct_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic             last_seen_q, last_seen_d;
   logic [PCT_W-1:0] accuracy_q, accuracy_d;
   logic             acc_valid_q, acc_valid_d;
   logic             overflow_q, overflow_d;

   logic             div_start;
   logic             div_abort;
   logic             div_done;
   logic [NUM_W-1:0] div_quot;
   logic [PCT_W-1:0] quot_pct;
   logic             is_match;

   seq_divider #(
      .N_W (NUM_W),
      .D_W (CNT_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .abort (div_abort),
      .num   (scale_pct(correct_q)),
      .den   (total_q),
      .done  (div_done),
      .quot  (div_quot)
   );

   // The quotient cannot exceed 100 since correct <= total; the clamp only guards odd inputs.
   assign quot_pct = (div_quot > NUM_W'(PCT_SCALE)) ? PCT_W'(PCT_SCALE) : div_quot[PCT_W-1:0];
   assign is_match = (res.res_pred == res.res_label);

   always_comb begin
      state_d     = state_q;
      correct_d   = correct_q;
      total_d     = total_q;
      last_seen_d = last_seen_q;
      accuracy_d  = accuracy_q;
      acc_valid_d = acc_valid_q;
      overflow_d  = overflow_q;
      div_start   = 1'b0;
      div_abort   = 1'b0;

      if (start) begin
         state_d     = SC_COLLECT;
         correct_d   = '0;
         total_d     = '0;
         last_seen_d = 1'b0;
         accuracy_d  = '0;
         acc_valid_d = 1'b0;
         overflow_d  = 1'b0;
         div_abort   = 1'b1;
      end else begin
         unique case (state_q)
            SC_IDLE: ;
            SC_COLLECT: begin
               // Decision cycle: counters are final, launch the divider unless nothing was counted.
               if ((total_q == CNT_W'(NUM_SAMPLES)) || last_seen_q) begin
                  state_d     = SC_DIVIDE;
                  last_seen_d = 1'b0;
                  div_start   = (total_q != '0);
               end else begin
                  if (res.res_valid) begin
                     total_d = total_q + CNT_W'(1);
                     if (is_match) correct_d = correct_q + CNT_W'(1);
                  end
                  if (res.last) last_seen_d = 1'b1;
               end
            end
            SC_DIVIDE: begin
               if (res.res_valid) overflow_d = 1'b1;
               if (total_q == '0) begin
                  state_d     = SC_REPORT;
                  accuracy_d  = '0;
                  acc_valid_d = 1'b1;
               end else if (div_done) begin
                  state_d     = SC_REPORT;
                  accuracy_d  = quot_pct;
                  acc_valid_d = 1'b1;
               end
            end
            SC_REPORT: begin
               if (res.res_valid) overflow_d = 1'b1;
            end
            default: state_d = SC_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SC_IDLE;
         correct_q   <= '0;
         total_q     <= '0;
         last_seen_q <= 1'b0;
         accuracy_q  <= '0;
         acc_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         correct_q   <= correct_d;
         total_q     <= total_d;
         last_seen_q <= last_seen_d;
         accuracy_q  <= accuracy_d;
         acc_valid_q <= acc_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign res.sample_idx = total_q;
   assign correct_cnt    = correct_q;
   assign total_cnt      = total_q;
   assign accuracy       = accuracy_q;
   assign acc_valid      = acc_valid_q;
   assign overflow       = overflow_q;
   assign busy           = (state_q == SC_COLLECT) || (state_q == SC_DIVIDE);

endmodule

// File: tb/tb_nn_result_scorer.sv
// Scoreboard bench for nn_result_scorer: stimulus pushes expected reports, a monitor checks each acc_valid rise.
module tb_nn_result_scorer;
   import nn_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] correct_cnt;
   logic [CNT_W-1:0] total_cnt;
   logic [PCT_W-1:0] accuracy;
   logic             acc_valid;
   logic             busy;
   logic             overflow;

   nn_result_scorer_if rif ();

   nn_result_scorer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .res         (rif),
      .correct_cnt (correct_cnt),
      .total_cnt   (total_cnt),
      .accuracy    (accuracy),
      .acc_valid   (acc_valid),
      .busy        (busy),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Combinational label ROM addressed by the scorer's sample index
   function automatic logic [7:0] lbl(input int idx);
      return 8'((idx * 37 + 11) % 256);
   endfunction
   assign rif.res_label = lbl(int'(rif.sample_idx));

   typedef struct {
      int correct;
      int total;
      int acc;
      int idx;
      int due;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   k;
   int   last_edge;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input bit match, input bit with_last);
      logic [7:0] l;
      l = lbl(k);
      rif.res_valid = 1'b1;
      rif.res_pred  = match ? l : l + 8'd1;
      rif.last      = with_last;
      last_edge     = cyc + 1;
      tick();
      rif.res_valid = 1'b0;
      rif.last      = 1'b0;
      k++;
   endtask

   task automatic send_last();
      rif.last  = 1'b1;
      last_edge = cyc + 1;
      tick();
      rif.last  = 1'b0;
   endtask

   task automatic push(input int c, input int t, input int a, input int lat);
      exp_t e;
      e.correct = c;
      e.total   = t;
      e.acc     = a;
      e.idx     = t;
      e.due     = last_edge + lat;
      sb.push_back(e);
   endtask

   task automatic wait_acc(input int budget);
      for (int i = 0; i < budget && !acc_valid; i++) tick();
      check("acc_valid_seen", int'(acc_valid), 1);
   endtask

   // Monitor: each rising acc_valid must match the oldest queued expectation
   initial begin
      bit   acc_prev;
      exp_t e;
      acc_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (acc_valid && !acc_prev) begin
            if (sb.size() == 0) begin
               check("unexpected_acc_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               $display("report: correct=%0d total=%0d accuracy=%0d idx=%0d edge=%0d", correct_cnt,
                        total_cnt, accuracy, rif.sample_idx, cyc);
               check("rpt_accuracy", int'(accuracy), e.acc);
               check("rpt_correct", int'(correct_cnt), e.correct);
               check("rpt_total", int'(total_cnt), e.total);
               check("rpt_sample_idx", int'(rif.sample_idx), e.idx);
               check("rpt_busy", int'(busy), 0);
               check("rpt_latency_edge", cyc, e.due);
            end
         end
         acc_prev = acc_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      rif.res_valid = 1'b0;
      rif.res_pred  = '0;
      rif.last      = 1'b0;
      k             = 0;
      last_edge     = 0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state, and res_valid in IDLE before any start must not raise overflow
      check("rst_correct", int'(correct_cnt), 0);
      check("rst_total", int'(total_cnt), 0);
      check("rst_accuracy", int'(accuracy), 0);
      check("rst_acc_valid", int'(acc_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_sample_idx", int'(rif.sample_idx), 0);
      send(1'b1, 1'b0);
      tick();
      check("idle_overflow", int'(overflow), 0);
      check("idle_total", int'(total_cnt), 0);

      // Full set, all matching
      do_start();
      check("start_busy", int'(busy), 1);
      k = 0;
      for (int i = 0; i < NUM_SAMPLES; i++) send(1'b1, 1'b0);
      push(750, 750, 100, 18);
      wait_acc(40);

      // Full set, every tenth sample wrong: 675 correct
      do_start();
      k = 0;
      for (int i = 0; i < NUM_SAMPLES; i++) send((i % 10) != 0, 1'b0);
      push(675, 750, 90, 18);
      wait_acc(40);

      // Three samples, one match, then last on its own
      do_start();
      k = 0;
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      send_last();
      push(1, 3, 33, 18);
      wait_acc(40);

      // No samples at all: division skipped
      do_start();
      k = 0;
      send_last();
      push(0, 0, 0, 2);
      wait_acc(10);

      // Final sample carries last: 4 of 5
      do_start();
      k = 0;
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b1);
      push(4, 5, 80, 18);
      wait_acc(40);

      // Stray result during REPORT
      rif.res_valid = 1'b1;
      rif.res_pred  = '0;
      tick();
      rif.res_valid = 1'b0;
      tick();
      check("report_overflow", int'(overflow), 1);
      check("report_total", int'(total_cnt), 5);
      check("report_correct", int'(correct_cnt), 4);
      check("report_acc_valid", int'(acc_valid), 1);
      check("report_accuracy", int'(accuracy), 80);

      // start in DIVIDE aborts the division
      do_start();
      check("restart_overflow", int'(overflow), 0);
      k = 0;
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send_last();
      repeat (5) tick();
      do_start();
      check("abort_correct", int'(correct_cnt), 0);
      check("abort_total", int'(total_cnt), 0);
      check("abort_acc_valid", int'(acc_valid), 0);
      check("abort_accuracy", int'(accuracy), 0);
      check("abort_busy", int'(busy), 1);
      repeat (25) tick();
      check("abort_no_report", int'(acc_valid), 0);
      k = 0;
      send_last();
      push(0, 0, 0, 2);
      wait_acc(10);

      // Reset mid-collection
      do_start();
      k = 0;
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_total", int'(total_cnt), 0);
      check("midrst_correct", int'(correct_cnt), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_acc_valid", int'(acc_valid), 0);

      repeat (5) tick();
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
